// File: rtl/sw_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pulse_gen
//  Description : Converts a BCD digit into that many level toggles on a
//                switch-style line. Each toggle is held for HOLD_CYC clocks,
//                and the line is also held for HOLD_CYC clocks after the last
//                toggle. A switch edge-counter that counts rises and falls
//                therefore advances by exactly the digit sent.
//  Revision    : 1.0  initial release
// ============================================================================
module sw_pulse_gen #(
    parameter int HOLD_CYC = 4,
    parameter int TW       = 8
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       start,
    input  logic [3:0] count_in,
    output logic       sw_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] left
);

    // The receiver uses a 2-stage sampler, so shorter holds could be missed.
    // The timer must also be wide enough to hold HOLD_CYC-1.
    generate
        if (HOLD_CYC < 2) begin : g_bad_hold
            $error("sw_pulse_gen: HOLD_CYC must be >= 2");
        end
        if ((2 ** TW) <= HOLD_CYC) begin : g_bad_tw
            $error("sw_pulse_gen: TW too narrow for HOLD_CYC");
        end
    endgenerate

    localparam logic [TW-1:0] HOLD_RELOAD = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [3:0]      sat_count;

    // Digits above 9 are not valid BCD; clamp them to the largest digit.
    assign sat_count = (count_in > 4'd9) ? 4'd9 : count_in;

    // Transfer sequencer: all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state  <= IDLE;
            timer  <= '0;
            sw_out <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            left   <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (sat_count == 4'd0) begin
                            // Nothing to send: complete immediately, line untouched.
                            done <= 1'b1;
                        end else begin
                            left  <= sat_count;
                            timer <= HOLD_RELOAD;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (timer != '0) begin
                        timer <= timer - TIMER_ONE;
                    end else begin
                        sw_out <= ~sw_out;
                        left   <= left - 4'd1;
                        timer  <= HOLD_RELOAD;
                        if (left == 4'd1) begin
                            state <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    // Hold the final level long enough for the receiver to see it.
                    if (timer != '0) begin
                        timer <= timer - TIMER_ONE;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    left  <= 4'd0;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
